// File: rtl/window3x3_filter_pkg.sv
// Shared definitions for the 3x3 window filter.
//   mode_e     : run-time filter selection (bypass, mean, Sobel, thresholded Sobel)
//   MeanMul /
//   MeanShift  : fixed-point reciprocal of 9 used by the mean filter (57/512 ~= 1/9)
package window3x3_filter_pkg;

  typedef enum logic [1:0] {
    ModeBypass   = 2'd0,
    ModeMean     = 2'd1,
    ModeSobel    = 2'd2,
    ModeSobelBin = 2'd3
  } mode_e;

  localparam int unsigned MeanMul   = 57;
  localparam int unsigned MeanShift = 9;

endpackage

// File: rtl/window3x3_filter_if.sv
// Gray pixel stream bundle, used for both the filter input and output.
//   valid : pixel strobe (no backpressure)
//   data  : pixel value, DW bits
//   sof   : first pixel of a frame, qualified by valid
//   eol   : last pixel of a line, qualified by valid
// master drives the stream, slave receives it.
interface window3x3_filter_if #(
  parameter int unsigned DW = 8
) ();

  logic          valid;
  logic [DW-1:0] data;
  logic          sof;
  logic          eol;

  modport master (output valid, output data, output sof, output eol);
  modport slave  (input  valid, input  data, input  sof, input  eol);

endinterface

// File: rtl/line_ram_rbw.sv
// Simple dual-port line RAM: one write port, one synchronous read port.
// A read and a write to the same address in one cycle returns the old contents.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_re    : read enable; o_rdata updates one cycle later and holds otherwise
//   i_raddr : read address
//   o_rdata : registered read data
// Contents are not reset.
module line_ram_rbw #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/window3x3_filter.sv
// 3x3 neighbourhood filter on a gray pixel stream.
// Two line RAMs hold the previous two lines; a 3x3 window is shifted on every accepted pixel
// and one filtered pixel is produced per input pixel, exactly 3 cycles later.
//   clk            : clock
//   rst_n          : synchronous, active-low reset
//   i_mode         : 0 bypass, 1 mean, 2 Sobel |gx|+|gy|, 3 Sobel binarised; latched at sof
//   i_pix          : input stream (valid/data/sof/eol)
//   o_pix          : output stream, same geometry, sof/eol delayed with the data
//   o_err_overflow : sticky, a line exceeded MAX_W pixels; cleared at the next accepted sof
// Pipeline: c0 accept + RAM read, c1 window shift, c2 arithmetic, c3 output register.
module window3x3_filter
  import window3x3_filter_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned MAX_W      = 2048,
  parameter int unsigned BORDER_VAL = 66,
  parameter int unsigned THRESH     = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         i_mode,
  window3x3_filter_if.slave  i_pix,
  window3x3_filter_if.master o_pix,
  output logic               o_err_overflow
);

  localparam int unsigned AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int unsigned CW = $clog2(MAX_W) + 1;

  localparam logic [DW-1:0] PixMax  = {DW{1'b1}};
  localparam logic [DW-1:0] BordVal = DW'(BORDER_VAL);
  localparam logic [CW-1:0] ColMax  = CW'(MAX_W);

  // ---------------------------------------------------------------------------
  // Stage 0: accept, position counters, RAM read
  // ---------------------------------------------------------------------------
  logic          r_armed;
  logic [CW-1:0] r_col;
  logic [1:0]    r_row;
  mode_e         r_mode;
  logic          r_err;

  logic          w_acc;
  logic [CW-1:0] w_col;
  logic [1:0]    w_row;
  mode_e         w_mode;
  logic          w_ovf;
  logic          w_border;
  logic [AW-1:0] w_addr;

  // sof applies to the pixel it arrives with, so the current position is muxed here.
  always_comb begin
    w_acc    = i_pix.valid & (r_armed | i_pix.sof);
    w_col    = i_pix.sof ? '0 : r_col;
    w_row    = i_pix.sof ? 2'd0 : r_row;
    w_mode   = i_pix.sof ? mode_e'(i_mode) : r_mode;
    w_ovf    = (w_col >= ColMax);
    w_border = (w_row < 2'd2) | (w_col < CW'(2)) | w_ovf;
    w_addr   = w_col[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_col   <= '0;
      r_row   <= 2'd0;
      r_mode  <= ModeBypass;
      r_err   <= 1'b0;
    end else begin
      if (i_pix.valid & i_pix.sof) begin
        r_armed <= 1'b1;
      end
      if (w_acc) begin
        r_mode <= w_mode;
        if (i_pix.eol) begin
          r_col <= '0;
          r_row <= (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
        end else begin
          // Hold at MAX_W so a runaway line cannot wrap back into valid columns.
          r_col <= w_ovf ? ColMax : w_col + CW'(1);
          r_row <= w_row;
        end
        if (i_pix.sof) begin
          r_err <= 1'b0;
        end else if (w_ovf) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign o_err_overflow = r_err;

  // ---------------------------------------------------------------------------
  // Stage 1 registers and line RAMs
  // ---------------------------------------------------------------------------
  logic          r_v1;
  logic [DW-1:0] r_pix1;
  logic          r_sof1;
  logic          r_eol1;
  logic          r_bord1;
  mode_e         r_mode1;
  logic          r_we1;
  logic [AW-1:0] r_addr1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_pix1  <= '0;
      r_sof1  <= 1'b0;
      r_eol1  <= 1'b0;
      r_bord1 <= 1'b0;
      r_mode1 <= ModeBypass;
      r_we1   <= 1'b0;
      r_addr1 <= '0;
    end else begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_pix1  <= i_pix.data;
        r_sof1  <= i_pix.sof;
        r_eol1  <= i_pix.eol;
        r_bord1 <= w_border;
        r_mode1 <= w_mode;
        r_we1   <= ~w_ovf;
        r_addr1 <= w_addr;
      end
    end
  end

  logic [DW-1:0] w_ram0_q;
  logic [DW-1:0] w_ram1_q;

  // RAM0: line r-1. Written with the incoming pixel at its column.
  line_ram_rbw #(
    .DW    (DW),
    .DEPTH (MAX_W),
    .AW    (AW)
  ) u_ram0 (
    .clk     (clk),
    .i_we    (w_acc & ~w_ovf),
    .i_waddr (w_addr),
    .i_wdata (i_pix.data),
    .i_re    (w_acc),
    .i_raddr (w_addr),
    .o_rdata (w_ram0_q)
  );

  // RAM1: line r-2. Takes the old RAM0 word one cycle later, once its read data is out.
  line_ram_rbw #(
    .DW    (DW),
    .DEPTH (MAX_W),
    .AW    (AW)
  ) u_ram1 (
    .clk     (clk),
    .i_we    (r_v1 & r_we1),
    .i_waddr (r_addr1),
    .i_wdata (w_ram0_q),
    .i_re    (w_acc),
    .i_raddr (w_addr),
    .o_rdata (w_ram1_q)
  );

  // ---------------------------------------------------------------------------
  // Stage 2: window shift (only on accepted pixels so gaps leave it intact)
  // r_win[row][col]: row 0 = r-2 (top), row 2 = r (bottom); col 2 = newest.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] r_win [3][3];
  logic          r_v2;
  logic          r_sof2;
  logic          r_eol2;
  logic          r_bord2;
  mode_e         r_mode2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_win[i][j] <= '0;
        end
      end
      r_v2    <= 1'b0;
      r_sof2  <= 1'b0;
      r_eol2  <= 1'b0;
      r_bord2 <= 1'b0;
      r_mode2 <= ModeBypass;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= r_win[i][2];
        end
        r_win[0][2] <= w_ram1_q;
        r_win[1][2] <= w_ram0_q;
        r_win[2][2] <= r_pix1;
        r_sof2      <= r_sof1;
        r_eol2      <= r_eol1;
        r_bord2     <= r_bord1;
        r_mode2     <= r_mode1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arithmetic (combinational, feeding the output register)
  // ---------------------------------------------------------------------------
  // a + 2b + c, wide enough for 4 * (2^DW - 1).
  function automatic logic [DW+1:0] wsum(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  logic [DW+3:0] w_sum9;
  logic [DW+9:0] w_mean_prod;
  logic [DW+9:0] w_mean_shr;
  logic [DW-1:0] w_mean;
  logic [DW+1:0] w_gx_p, w_gx_n, w_gy_p, w_gy_n;
  logic [DW+1:0] w_agx, w_agy;
  logic [DW+2:0] w_mag;
  logic [DW-1:0] w_sobel;
  logic [DW-1:0] w_sobel_bin;
  logic [DW-1:0] w_res;

  always_comb begin
    w_sum9 = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w_sum9 = w_sum9 + (DW+4)'(r_win[i][j]);
      end
    end
    w_mean_prod = (DW+10)'(w_sum9) * (DW+10)'(MeanMul);
    w_mean_shr  = w_mean_prod >> MeanShift;
    w_mean      = (w_mean_shr > (DW+10)'(PixMax)) ? PixMax : w_mean_shr[DW-1:0];

    w_gx_p = wsum(r_win[0][2], r_win[1][2], r_win[2][2]);
    w_gx_n = wsum(r_win[0][0], r_win[1][0], r_win[2][0]);
    w_gy_p = wsum(r_win[2][0], r_win[2][1], r_win[2][2]);
    w_gy_n = wsum(r_win[0][0], r_win[0][1], r_win[0][2]);
    w_agx  = (w_gx_p >= w_gx_n) ? w_gx_p - w_gx_n : w_gx_n - w_gx_p;
    w_agy  = (w_gy_p >= w_gy_n) ? w_gy_p - w_gy_n : w_gy_n - w_gy_p;
    w_mag  = {1'b0, w_agx} + {1'b0, w_agy};

    w_sobel     = (w_mag > (DW+3)'(PixMax)) ? PixMax : w_mag[DW-1:0];
    w_sobel_bin = (w_mag >= (DW+3)'(THRESH)) ? PixMax : '0;

    w_res = r_win[1][1];
    case (r_mode2)
      ModeMean:     w_res = w_mean;
      ModeSobel:    w_res = w_sobel;
      ModeSobelBin: w_res = w_sobel_bin;
      default:      w_res = r_win[1][1];
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 3: output register
  // ---------------------------------------------------------------------------
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic          r_out_sof;
  logic          r_out_eol;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
    end else begin
      r_out_valid <= r_v2;
      r_out_sof   <= r_v2 & r_sof2;
      r_out_eol   <= r_v2 & r_eol2;
      if (r_v2) begin
        r_out_data <= r_bord2 ? BordVal : w_res;
      end
    end
  end

  assign o_pix.valid = r_out_valid;
  assign o_pix.data  = r_out_data;
  assign o_pix.sof   = r_out_sof;
  assign o_pix.eol   = r_out_eol;

endmodule

// File: tb/tb_window3x3_filter.sv
// Directed bench for window3x3_filter (MAX_W = 16 so a 20-pixel line overflows).
// Expected pixels come from hand-derived tables per pattern/mode/column.
module tb_window3x3_filter;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       err;

  window3x3_filter_if #(.DW(8)) u_in ();
  window3x3_filter_if #(.DW(8)) u_out ();

  window3x3_filter #(
    .DW         (8),
    .MAX_W      (16),
    .BORDER_VAL (66),
    .THRESH     (128)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_mode         (mode),
    .i_pix          (u_in),
    .o_pix          (u_out),
    .o_err_overflow (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_out = 0;
  bit mon_en;

  int         exp_data_q[$];
  logic [1:0] exp_se_q[$];
  int         exp_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: every out_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (mon_en && u_out.valid === 1'b1) begin
      n_out++;
      check_eq("out_expected", 32'(exp_data_q.size() > 0), 1);
      if (exp_data_q.size() > 0) begin
        check_eq("out_data", 32'(u_out.data), 32'(exp_data_q.pop_front()));
        check_eq("out_sof_eol", 32'({u_out.sof, u_out.eol}), 32'(exp_se_q.pop_front()));
        check_eq("out_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end
  end

  function automatic int pix_of(input int pat, input int c);
    int r;
    if (pat == 0) r = 100;
    else r = (c < 4) ? 0 : 200;
    return r;
  endfunction

  // Hand-derived outputs. pat 0: flat 100; pat 1: cols 0-3 = 0, cols 4-7 = 200.
  // Mean edge: cols{2,3,4}=600*57>>9=66, cols{3,4,5}=1200*57>>9=133, flat 200 -> 200.
  function automatic int exp_of(input int pat, input int emode, input int row, input int c);
    int r;
    if (row < 2 || c < 2 || c >= 16) r = 66;
    else if (pat == 0) r = (emode >= 2) ? 0 : 100;
    else begin
      case (emode)
        0: r = (c >= 5) ? 200 : 0;
        1: begin
          if (c == 4) r = 66;
          else if (c == 5) r = 133;
          else r = (c >= 6) ? 200 : 0;
        end
        default: r = (c == 4 || c == 5) ? 255 : 0;
      endcase
    end
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      u_in.valid = 1'b0;
      u_in.sof   = 1'b0;
      u_in.eol   = 1'b0;
      u_in.data  = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic push_pix(input logic [7:0] d, input bit sof, input bit eol, input bit expect_out,
                          input int exp_val);
    @(posedge clk);
    #1;
    u_in.valid = 1'b1;
    u_in.data  = d;
    u_in.sof   = sof;
    u_in.eol   = eol;
    if (expect_out) begin
      exp_data_q.push_back(exp_val);
      exp_se_q.push_back({sof, eol});
      exp_cyc_q.push_back(cyc + 3);
    end
  endtask

  task automatic send_line(input int row, input int w, input int pat, input int emode,
                           input bit gaps, input bit expect_out);
    for (int c = 0; c < w; c++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 1));
      push_pix(8'(pix_of(pat, c)), (row == 0) && (c == 0), c == w - 1, expect_out,
               exp_of(pat, emode, row, c));
    end
  endtask

  task automatic send_frame(input int pat, input int emode, input bit gaps);
    for (int r = 0; r < 4; r++) send_line(r, 8, pat, emode, gaps, 1'b1);
    idle(6);
    check_eq("drained", 32'(exp_data_q.size()), 0);
  endtask

  int n_out_snap;

  initial begin
    mon_en     = 1'b1;
    rst_n      = 1'b0;
    mode       = 2'd0;
    u_in.valid = 1'b0;
    u_in.data  = 8'd0;
    u_in.sof   = 1'b0;
    u_in.eol   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(u_out.valid), 0);
    check_eq("rst_data", 32'(u_out.data), 0);
    check_eq("rst_sof_eol", 32'({u_out.sof, u_out.eol}), 0);
    check_eq("rst_err", 32'(err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Unarmed: pixels without a prior sof are ignored.
    for (int c = 0; c < 5; c++) push_pix(8'd50, 1'b0, c == 4, 1'b0, 0);
    idle(6);
    check_eq("no_out_before_sof", 32'(n_out), 0);

    mode = 2'd1;
    send_frame(0, 1, 1'b0);   // flat mean
    send_frame(1, 1, 1'b0);   // edge mean
    mode = 2'd2;
    send_frame(1, 2, 1'b0);   // edge Sobel

    // Binarised Sobel; mode change after row 1 must not apply until the next sof.
    mode = 2'd3;
    send_line(0, 8, 1, 3, 1'b0, 1'b1);
    send_line(1, 8, 1, 3, 1'b0, 1'b1);
    mode = 2'd0;
    send_line(2, 8, 1, 3, 1'b0, 1'b1);
    send_line(3, 8, 1, 3, 1'b0, 1'b1);
    idle(6);
    check_eq("drained_modeswitch", 32'(exp_data_q.size()), 0);
    send_frame(1, 0, 1'b0);   // now bypass

    // Gaps must give the same data as the gap-free Sobel run.
    mode = 2'd2;
    send_frame(1, 2, 1'b1);

    // Overflow: three 20-pixel lines then an 8-pixel line.
    check_eq("err_before_ovf", 32'(err), 0);
    mode = 2'd1;
    send_line(0, 20, 0, 1, 1'b0, 1'b1);
    send_line(1, 20, 0, 1, 1'b0, 1'b1);
    send_line(2, 20, 0, 1, 1'b0, 1'b1);
    send_line(3, 8, 0, 1, 1'b0, 1'b1);
    idle(6);
    check_eq("drained_ovf", 32'(exp_data_q.size()), 0);
    check_eq("err_set", 32'(err), 1);
    send_frame(0, 1, 1'b0);
    check_eq("err_cleared", 32'(err), 0);

    // Reset mid-line: in-flight pixels dropped, nothing until a new sof.
    mon_en = 1'b0;
    for (int c = 0; c < 3; c++) push_pix(8'd100, c == 0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    u_in.valid = 1'b0;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_valid", 32'(u_out.valid), 0);
    check_eq("midrst_data", 32'(u_out.data), 0);
    check_eq("midrst_sof_eol", 32'({u_out.sof, u_out.eol}), 0);
    mon_en     = 1'b1;
    n_out_snap = n_out;
    for (int c = 0; c < 8; c++) push_pix(8'd100, 1'b0, c == 7, 1'b0, 0);
    idle(6);
    check_eq("no_out_after_rst", 32'(n_out), 32'(n_out_snap));
    mode = 2'd2;
    send_frame(1, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
